// File: rtl/random_generator_if.sv
// random_generator_if
//   Request/response bundle between a random-number consumer and
//   random_generator.
//   en_rng       : draw request (consumer -> generator)
//   rng_out      : last generated 16-bit word
//   rng_out_4bit : {12'h000, rng_out[3:0]}
//   done         : one-cycle strobe, outputs valid from this cycle on
interface random_generator_if;
    logic        en_rng;
    logic [15:0] rng_out;
    logic [15:0] rng_out_4bit;
    logic        done;

    modport master (output en_rng, input rng_out, rng_out_4bit, done);
    modport slave  (input en_rng, output rng_out, rng_out_4bit, done);
endinterface

// File: rtl/random_generator.sv
// random_generator
//   16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
//   A request sampled in IDLE shifts 16 fresh bits into the LFSR, then
//   publishes the word and a one-cycle done strobe.
//   clock : rising-edge clock
//   nrst  : asynchronous, active-high reset
//   bus   : slave side of random_generator_if (en_rng in; rng_out,
//           rng_out_4bit, done out)
module random_generator #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                clock,
    input  logic                nrst,
    random_generator_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] s_q, s_d;
    logic [15:0] rng_q, rng_d;
    logic [15:0] rng4_q, rng4_d;
    logic        done_q, done_d;
    logic        fb;

    assign fb = s_q[15] ^ s_q[13] ^ s_q[12] ^ s_q[10];

    // State register plus datapath flops
    always_ff @(posedge clock or posedge nrst) begin
        if (nrst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            s_q     <= SEED;
            rng_q   <= 16'h0000;
            rng4_q  <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            rng_q   <= rng_d;
            rng4_q  <= rng4_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; en_rng only matters in IDLE, so requests are never queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en_rng) state_d = SHIFT;
            SHIFT:   if (cnt_q == 4'd15) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        s_d    = s_q;
        cnt_d  = cnt_q;
        rng_d  = rng_q;
        rng4_d = rng4_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (bus.en_rng) cnt_d = 4'd0;
            SHIFT: begin
                // An all-zero LFSR would lock up; reseed instead of shifting
                s_d   = (s_q == 16'h0000) ? SEED : {s_q[14:0], fb};
                cnt_d = cnt_q + 4'd1;
            end
            LOAD: begin
                rng_d  = s_q;
                rng4_d = {12'h000, s_q[3:0]};
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rng_out      = rng_q;
    assign bus.rng_out_4bit = rng4_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_random_generator.sv
module tb_random_generator;
    logic clock = 1'b0;
    logic nrst  = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [15:0] seed_v = 16'hACE1;

    random_generator_if bus();

    random_generator dut (.clock(clock), .nrst(nrst), .bus(bus));

    always #5 clock = ~clock;

    // Reference model: the raw bit stream. Each new bit is
    // x[n] = x[n-16] ^ x[n-14] ^ x[n-13] ^ x[n-11]; the word is the last 16 bits.
    bit hist[$];

    function automatic void model_reset();
        hist.delete();
        for (int i = 15; i >= 0; i--) hist.push_back(seed_v[i]);
    endfunction

    function automatic void model_step();
        bit nb;
        nb = hist[0] ^ hist[2] ^ hist[3] ^ hist[5];
        void'(hist.pop_front());
        hist.push_back(nb);
    endfunction

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = hist[i];
        return w;
    endfunction

    function automatic logic [15:0] model_draw();
        for (int i = 0; i < 16; i++) model_step();
        return model_word();
    endfunction

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // One-cycle request; returns one time unit after the sampling edge E0
    task automatic pulse_en();
        bus.en_rng = 1'b1;
        tick();
        bus.en_rng = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit found);
        found = 1'b0;
        cycles = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                cycles = k;
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clock); #3;
        nrst = 1'b1;
        #1;
        n_chk++; if (bus.rng_out !== 16'h0000) $display("FAIL reset_async_rng_out got=%h exp=0000", bus.rng_out); else n_pass++;
        n_chk++; if (bus.rng_out_4bit !== 16'h0000) $display("FAIL reset_async_rng4 got=%h exp=0000", bus.rng_out_4bit); else n_pass++;
        n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_async_done got=%b exp=0", bus.done); else n_pass++;
        repeat (3) tick();
        n_chk++; if (dut.s_q !== seed_v) $display("FAIL reset_lfsr got=%h exp=%h", dut.s_q, seed_v); else n_pass++;
        n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_hold_done got=%b exp=0", bus.done); else n_pass++;
        nrst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_draw();
        logic [15:0] exp;
        pulse_en();
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1) begin
                model_step();
                n_chk++; if (dut.s_q !== model_word()) $display("FAIL single_step got=%h exp=%h", dut.s_q, model_word()); else n_pass++;
                n_chk++; if (dut.s_q !== 16'h59C3) $display("FAIL single_step_const got=%h exp=59c3", dut.s_q); else n_pass++;
            end
            n_chk++; if (bus.done !== (k == 17)) $display("FAIL first_done_timing k=%0d got=%b exp=%b", k, bus.done, (k == 17)); else n_pass++;
            if (k < 17) begin
                n_chk++; if (bus.rng_out !== 16'h0000) $display("FAIL first_hold k=%0d got=%h exp=0000", k, bus.rng_out); else n_pass++;
            end
            if (k == 17) begin
                for (int i = 0; i < 15; i++) model_step();
                exp = model_word();
                n_chk++; if (bus.rng_out !== exp) $display("FAIL first_rng_model got=%h exp=%h", bus.rng_out, exp); else n_pass++;
                n_chk++; if (bus.rng_out !== 16'hE455) $display("FAIL first_rng_const got=%h exp=e455", bus.rng_out); else n_pass++;
                n_chk++; if (bus.rng_out_4bit !== 16'h0005) $display("FAIL first_rng4 got=%h exp=0005", bus.rng_out_4bit); else n_pass++;
            end
        end
    endtask

    task automatic test_second_draw();
        logic [15:0] exp;
        repeat (5) tick();
        pulse_en();
        for (int k = 1; k <= 18; k++) begin
            tick();
            n_chk++; if (bus.done !== (k == 17)) $display("FAIL second_done_timing k=%0d got=%b exp=%b", k, bus.done, (k == 17)); else n_pass++;
            if (k < 17) begin
                n_chk++;
                if (bus.rng_out !== 16'hE455 || bus.rng_out_4bit !== 16'h0005)
                    $display("FAIL second_hold k=%0d got=%h/%h exp=e455/0005", k, bus.rng_out, bus.rng_out_4bit);
                else n_pass++;
            end
            if (k == 17) begin
                exp = model_draw();
                n_chk++; if (bus.rng_out !== exp) $display("FAIL second_rng_model got=%h exp=%h", bus.rng_out, exp); else n_pass++;
                n_chk++; if (bus.rng_out !== 16'hDD17) $display("FAIL second_rng_const got=%h exp=dd17", bus.rng_out); else n_pass++;
                n_chk++; if (bus.rng_out_4bit !== 16'h0007) $display("FAIL second_rng4 got=%h exp=0007", bus.rng_out_4bit); else n_pass++;
            end
        end
    endtask

    task automatic test_busy();
        int j, ndone, at;
        logic [15:0] got, exp;
        j = $urandom_range(2, 13);
        ndone = 0; at = 0; got = 16'h0;
        pulse_en();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                ndone++;
                at = k;
                got = bus.rng_out;
            end
            bus.en_rng = (k == j);
        end
        bus.en_rng = 1'b0;
        exp = model_draw();
        n_chk++; if (ndone !== 1) $display("FAIL busy_done_count got=%0d exp=1", ndone); else n_pass++;
        n_chk++; if (at !== 17) $display("FAIL busy_done_cycle got=%0d exp=17", at); else n_pass++;
        n_chk++; if (got !== exp) $display("FAIL busy_rng got=%h exp=%h", got, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n, cnt;
        logic [15:0] exp;
        n = $urandom_range(3, 5);
        cnt = 0;
        bus.en_rng = 1'b1;
        for (int k = 1; k <= n * 18 + 6; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                exp = model_draw();
                n_chk++; if (k !== 18 * (cnt + 1)) $display("FAIL b2b_period draw=%0d got_cycle=%0d exp_cycle=%0d", cnt, k, 18 * (cnt + 1)); else n_pass++;
                n_chk++; if (bus.rng_out !== exp) $display("FAIL b2b_rng draw=%0d got=%h exp=%h", cnt, bus.rng_out, exp); else n_pass++;
                n_chk++; if (bus.rng_out_4bit !== {12'h000, exp[3:0]}) $display("FAIL b2b_rng4 draw=%0d got=%h exp=%h", cnt, bus.rng_out_4bit, {12'h000, exp[3:0]}); else n_pass++;
                cnt++;
                if (cnt == n) bus.en_rng = 1'b0;
            end
        end
        bus.en_rng = 1'b0;
        n_chk++; if (cnt !== n) $display("FAIL b2b_draw_count got=%0d exp=%0d", cnt, n); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int ndone, cyc;
        bit found;
        logic [15:0] exp;
        pulse_en();
        repeat (7) tick();
        @(posedge clock); #2;           // just after E8
        nrst = 1'b1;
        #1;
        n_chk++; if (bus.done !== 1'b0 || bus.rng_out !== 16'h0000) $display("FAIL midrst_async got=%b/%h exp=0/0000", bus.done, bus.rng_out); else n_pass++;
        repeat (2) tick();
        nrst = 1'b0;
        model_reset();
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        n_chk++; if (ndone !== 0) $display("FAIL midrst_no_done got=%0d exp=0", ndone); else n_pass++;
        pulse_en();
        wait_done(30, cyc, found);
        exp = model_draw();
        n_chk++; if (!found || cyc !== 17) $display("FAIL midrst_latency got=%0d exp=17", cyc); else n_pass++;
        n_chk++; if (bus.rng_out !== exp) $display("FAIL midrst_rng_model got=%h exp=%h", bus.rng_out, exp); else n_pass++;
        n_chk++; if (bus.rng_out !== 16'hE455) $display("FAIL midrst_rng_const got=%h exp=e455", bus.rng_out); else n_pass++;
    endtask

    task automatic test_random_draws();
        int cyc;
        bit found;
        logic [15:0] exp;
        for (int d = 0; d < 4; d++) begin
            repeat ($urandom_range(0, 6)) tick();
            pulse_en();
            wait_done(30, cyc, found);
            exp = model_draw();
            n_chk++; if (!found || cyc !== 17) $display("FAIL rand_latency draw=%0d got=%0d exp=17", d, cyc); else n_pass++;
            n_chk++; if (bus.rng_out !== exp) $display("FAIL rand_rng draw=%0d got=%h exp=%h", d, bus.rng_out, exp); else n_pass++;
            n_chk++; if (bus.rng_out_4bit !== {12'h000, exp[3:0]}) $display("FAIL rand_rng4 draw=%0d got=%h exp=%h", d, bus.rng_out_4bit, {12'h000, exp[3:0]}); else n_pass++;
            tick();
            n_chk++; if (bus.done !== 1'b0) $display("FAIL rand_done_width draw=%0d got=%b exp=0", d, bus.done); else n_pass++;
        end
    endtask

    initial begin
        bus.en_rng = 1'b0;
        test_reset();
        test_first_draw();
        test_second_draw();
        test_busy();
        test_back_to_back();
        test_random_draws();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
